// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter that sits on the CPU store path.
//   Stores to TX_ADDR push wr_data[7:0] into a TX FIFO. The FIFO is drained
//   by a serialiser that emits start bit, 8 data bits (LSB first) and a stop
//   bit, each DIVISOR clock cycles long. Back-to-back bytes share no idle gap.
//   Status register at STATUS_ADDR (combinational read, write-1-to-bit3 to
//   clear overflow):
//     bit0 = FIFO full, bit1 = FIFO empty, bit2 = frame in flight, bit3 = overflow
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   wr_en    CPU store valid
//   wr_addr  store byte address
//   wr_data  store data ([7:0] = TX byte, [3] = overflow clear on status)
//   rd_addr  load byte address
//   rd_data  status readback (0 for any other address)
//   uart_tx  serial output, idle high, registered
//   tx_busy  FIFO non-empty or frame in flight
module uart_tx_mmio #(
  parameter int unsigned DIVISOR     = 868,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] TX_ADDR     = 32'hF000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'hF000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] COUNT_RELOAD = CW'(DIVISOR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    head_byte;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head_byte  = fifo_mem[rd_ptr_reg[AW-1:0]];

  // ---------------------------------------------------------------- decode
  logic tx_sel;
  logic status_sel;
  logic pop;
  logic push;
  logic drop;
  logic ovf_clr;
  logic overflow_reg;

  assign tx_sel     = wr_en && (wr_addr == TX_ADDR);
  assign status_sel = wr_en && (wr_addr == STATUS_ADDR);
  // A full FIFO still accepts a byte when the serialiser pops in the same
  // cycle: the popped slot is the one being overwritten, and the pop has
  // already captured the old value into the shift register at this edge.
  assign push       = tx_sel && (!fifo_full || pop);
  assign drop       = tx_sel && fifo_full && !pop;
  assign ovf_clr    = status_sel && wr_data[3];

  // Only the TX byte and the clear bit of the store data are meaningful.
  logic unused_wr_data;
  assign unused_wr_data = ^{wr_data[31:8]};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      // A fresh overflow beats a clear issued in the same cycle.
      if (drop)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- serialiser
  state_t        state_reg,   state_next;
  logic [CW-1:0] count_reg,   count_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg,   shift_next;
  logic          tx_reg,      tx_next;
  logic          bit_end;

  assign bit_end = (count_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  // tx_next is the line level for the cycle after the edge, so uart_tx comes
  // straight from a flop and each level change lines up with a state change.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;

    if (state_reg != IDLE) begin
      count_next = bit_end ? COUNT_RELOAD : count_reg - 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = head_byte;
          count_next = COUNT_RELOAD;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle bit between.
            pop        = 1'b1;
            shift_next = head_byte;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  logic tx_active;
  assign tx_active = (state_reg != IDLE);
  assign uart_tx   = tx_reg;
  assign tx_busy   = !fifo_empty || tx_active;

  always_comb begin
    rd_data = '0;
    if (rd_addr == STATUS_ADDR) begin
      rd_data = {28'b0, overflow_reg, tx_active, fifo_empty, fifo_full};
    end
  end

endmodule
